zaxdma_traffic: RTL and testbench

//  AXI4 full-width burst initiator used as a DMA-path traffic source/sink.
//  On start it writes an LFSR pattern to a memory region in INCR bursts, then

---
 rtl/zaxdma_traffic_pkg.sv | 27 ++
 rtl/zaxdma_lfsr.sv | 26 ++
 rtl/zaxdma_traffic.sv | 259 +++++++++++++++++++++++++
 tb/tb_zaxdma_traffic.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zaxdma_traffic_pkg.sv
// rtl/zaxdma_traffic_pkg.sv - shared AXI constants, LFSR feedback rule and traffic FSM states
package zaxdma_traffic_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         LFSR_SEED_W    = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WADDR,
        S_WDATA,
        S_WRESP,
        S_RADDR,
        S_RDATA,
        S_DONE
    } traffic_state_t;

    // Feedback from the two top state bits; the test slave uses the same rule.
    function automatic logic lfsr_feedback(input logic msb, input logic msb_m1);
        return msb ^ msb_m1;
    endfunction

    function automatic logic [LFSR_SEED_W-1:0] lfsr_seed_word(input logic [LFSR_SEED_W-1:0] seed);
        return seed;
    endfunction

endpackage

// File: rtl/zaxdma_lfsr.sv
// rtl/zaxdma_lfsr.sv - bus-width LFSR with seed load and single-step advance
module zaxdma_lfsr
    import zaxdma_traffic_pkg::*;
#(
    parameter int DW = 64
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_load,
    input  logic [LFSR_SEED_W-1:0] i_seed,
    input  logic                   i_step,
    output logic [DW-1:0]          o_state
);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_state <= '0;
        end else if (i_load) begin
            // Seed sits in the top 32 bits, remaining bits start at zero.
            o_state <= DW'(lfsr_seed_word(i_seed)) << (DW - LFSR_SEED_W);
        end else if (i_step) begin
            o_state <= {o_state[DW-2:0], lfsr_feedback(o_state[DW-1], o_state[DW-2])};
        end
    end

endmodule

// File: rtl/zaxdma_traffic.sv
// rtl/zaxdma_traffic.sv - AXI4 burst initiator writing then verifying an LFSR pattern
module zaxdma_traffic
    import zaxdma_traffic_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 30,
    parameter int BUS_WIDTH     = 64,
    parameter int IW            = 1,
    parameter int MAXBURST      = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_start,
    input  logic [31:0]              i_seed,
    input  logic [ADDRESS_WIDTH-1:0] i_addr,
    input  logic [15:0]              i_nbeats,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err,
    output logic [15:0]              o_mismatches,

    output logic                     M_AXI_AWVALID,
    input  logic                     M_AXI_AWREADY,
    output logic [IW-1:0]            M_AXI_AWID,
    output logic [ADDRESS_WIDTH-1:0] M_AXI_AWADDR,
    output logic [7:0]               M_AXI_AWLEN,
    output logic [2:0]               M_AXI_AWSIZE,
    output logic [1:0]               M_AXI_AWBURST,

    output logic                     M_AXI_WVALID,
    input  logic                     M_AXI_WREADY,
    output logic [BUS_WIDTH-1:0]     M_AXI_WDATA,
    output logic [BUS_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                     M_AXI_WLAST,

    input  logic                     M_AXI_BVALID,
    output logic                     M_AXI_BREADY,
    input  logic [IW-1:0]            M_AXI_BID,
    input  logic [1:0]               M_AXI_BRESP,

    output logic                     M_AXI_ARVALID,
    input  logic                     M_AXI_ARREADY,
    output logic [IW-1:0]            M_AXI_ARID,
    output logic [ADDRESS_WIDTH-1:0] M_AXI_ARADDR,
    output logic [7:0]               M_AXI_ARLEN,
    output logic [2:0]               M_AXI_ARSIZE,
    output logic [1:0]               M_AXI_ARBURST,

    input  logic                     M_AXI_RVALID,
    output logic                     M_AXI_RREADY,
    input  logic [IW-1:0]            M_AXI_RID,
    input  logic [BUS_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]               M_AXI_RRESP,
    input  logic                     M_AXI_RLAST
);

    localparam int          BEAT_SHIFT = $clog2(BUS_WIDTH / 8);
    localparam logic [15:0] MAX_BEATS  = 16'(MAXBURST);

    traffic_state_t state, state_next;

    logic [ADDRESS_WIDTH-1:0] base_addr;
    logic [ADDRESS_WIDTH-1:0] cur_addr;
    logic [ADDRESS_WIDTH-1:0] burst_bytes;
    logic [15:0]              total_beats;
    logic [15:0]              remaining;
    logic [15:0]              beat_cnt;
    logic [15:0]              burst_beats;
    logic                     burst_last;
    logic                     final_burst;
    logic                     w_fire;
    logic                     b_fire;
    logic                     r_fire;
    logic                     lfsr_load;
    logic                     lfsr_step;
    logic [BUS_WIDTH-1:0]     lfsr_state;
    logic                     unused_ids;

    // Burst length derives from the not-yet-consumed beat count, so it is
    // stable for the whole address/data/response sequence of a burst.
    assign burst_beats = (remaining > MAX_BEATS) ? MAX_BEATS : remaining;
    assign burst_last  = (beat_cnt == burst_beats - 16'd1);
    assign final_burst = (remaining == burst_beats);
    assign burst_bytes = ADDRESS_WIDTH'(burst_beats) << BEAT_SHIFT;

    assign w_fire = M_AXI_WVALID && M_AXI_WREADY;
    assign b_fire = M_AXI_BVALID && M_AXI_BREADY;
    assign r_fire = M_AXI_RVALID && M_AXI_RREADY;

    assign lfsr_load = ((state == S_IDLE) && i_start) || (b_fire && final_burst);
    assign lfsr_step = w_fire || r_fire;

    assign M_AXI_AWID    = '0;
    assign M_AXI_AWADDR  = cur_addr;
    assign M_AXI_AWLEN   = 8'(burst_beats - 16'd1);
    assign M_AXI_AWSIZE  = 3'(BEAT_SHIFT);
    assign M_AXI_AWBURST = AXI_BURST_INCR;
    assign M_AXI_WDATA   = lfsr_state;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = burst_last;
    assign M_AXI_ARID    = '0;
    assign M_AXI_ARADDR  = cur_addr;
    assign M_AXI_ARLEN   = 8'(burst_beats - 16'd1);
    assign M_AXI_ARSIZE  = 3'(BEAT_SHIFT);
    assign M_AXI_ARBURST = AXI_BURST_INCR;

    assign unused_ids = ^{M_AXI_BID, M_AXI_RID};

    zaxdma_lfsr #(
        .DW(BUS_WIDTH)
    ) u_lfsr (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_load    (lfsr_load),
        .i_seed    (i_seed),
        .i_step    (lfsr_step),
        .o_state   (lfsr_state)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_next = (i_nbeats == 16'd0) ? S_DONE : S_WADDR;
                end
            end
            S_WADDR: begin
                M_AXI_AWVALID = 1'b1;
                if (M_AXI_AWREADY) begin
                    state_next = S_WDATA;
                end
            end
            S_WDATA: begin
                M_AXI_WVALID = 1'b1;
                if (M_AXI_WREADY && burst_last) begin
                    state_next = S_WRESP;
                end
            end
            S_WRESP: begin
                M_AXI_BREADY = 1'b1;
                if (M_AXI_BVALID) begin
                    state_next = final_burst ? S_RADDR : S_WADDR;
                end
            end
            S_RADDR: begin
                M_AXI_ARVALID = 1'b1;
                if (M_AXI_ARREADY) begin
                    state_next = S_RDATA;
                end
            end
            S_RDATA: begin
                M_AXI_RREADY = 1'b1;
                if (M_AXI_RVALID && burst_last) begin
                    state_next = final_burst ? S_DONE : S_RADDR;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            base_addr    <= '0;
            cur_addr     <= '0;
            total_beats  <= '0;
            remaining    <= '0;
            beat_cnt     <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
            o_mismatches <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        base_addr    <= i_addr;
                        cur_addr     <= i_addr;
                        total_beats  <= i_nbeats;
                        remaining    <= i_nbeats;
                        o_busy       <= 1'b1;
                        o_err        <= 1'b0;
                        o_mismatches <= '0;
                    end
                end
                S_WADDR, S_RADDR: begin
                    beat_cnt <= '0;
                end
                S_WDATA: begin
                    if (w_fire) begin
                        beat_cnt <= beat_cnt + 16'd1;
                    end
                end
                S_WRESP: begin
                    if (b_fire) begin
                        if (M_AXI_BRESP != AXI_RESP_OKAY) begin
                            o_err <= 1'b1;
                        end
                        // After the last write burst, rewind to the base for read-back.
                        if (final_burst) begin
                            cur_addr  <= base_addr;
                            remaining <= total_beats;
                        end else begin
                            cur_addr  <= cur_addr + burst_bytes;
                            remaining <= remaining - burst_beats;
                        end
                    end
                end
                S_RDATA: begin
                    if (r_fire) begin
                        beat_cnt <= beat_cnt + 16'd1;
                        if (M_AXI_RDATA != lfsr_state) begin
                            o_err <= 1'b1;
                            if (o_mismatches != 16'hFFFF) begin
                                o_mismatches <= o_mismatches + 16'd1;
                            end
                        end
                        if (M_AXI_RRESP != AXI_RESP_OKAY) begin
                            o_err <= 1'b1;
                        end
                        // Our beat count ends the burst; RLAST only has to agree with it.
                        if (M_AXI_RLAST != burst_last) begin
                            o_err <= 1'b1;
                        end
                        if (burst_last) begin
                            cur_addr  <= cur_addr + burst_bytes;
                            remaining <= remaining - burst_beats;
                        end
                    end
                end
                S_DONE: begin
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zaxdma_traffic.sv
// tb/tb_zaxdma_traffic.sv - directed bench for zaxdma_traffic with an LFSR-responding AXI slave
module tb_zaxdma_traffic;

    localparam int AW = 30;
    localparam int DW = 64;
    localparam int IW = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [31:0]   seed;
    logic [AW-1:0] addr;
    logic [15:0]   nbeats;
    logic          busy, done, err;
    logic [15:0]   mism;

    logic            awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic            arvalid, arready, rvalid, rready, rlast;
    logic [IW-1:0]   awid, arid, bid, rid;
    logic [AW-1:0]   awaddr, araddr;
    logic [7:0]      awlen, arlen;
    logic [2:0]      awsize, arsize;
    logic [1:0]      awburst, arburst, bresp, rresp;
    logic [DW-1:0]   wdata, rdata;
    logic [DW/8-1:0] wstrb;

    always #5 clk = ~clk;

    zaxdma_traffic #(
        .ADDRESS_WIDTH(AW), .BUS_WIDTH(DW), .IW(IW), .MAXBURST(16)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_seed(seed),
        .i_addr(addr), .i_nbeats(nbeats), .o_busy(busy), .o_done(done),
        .o_err(err), .o_mismatches(mism),
        .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready), .M_AXI_AWID(awid),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
        .M_AXI_AWBURST(awburst),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_WDATA(wdata),
        .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
        .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_BID(bid),
        .M_AXI_BRESP(bresp),
        .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready), .M_AXI_ARID(arid),
        .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
        .M_AXI_ARBURST(arburst),
        .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready), .M_AXI_RID(rid),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Slave knobs
    logic [31:0] slv_seed    = 32'h12345678;
    bit          bp_en       = 1'b0;
    int          bresp_burst = -1;
    int          rlast_early = -1;

    // Slave statistics
    logic [AW-1:0] aw_addr_q[$], ar_addr_q[$];
    logic [7:0]    aw_len_q[$], ar_len_q[$];
    int wr_bytes, wr_mism, wlast_bad, stab_bad, fixed_bad, r_beats, w_total;

    // Slave internal state
    logic [DW-1:0] wl, rl, p_wdata;
    logic [AW-1:0] p_awaddr, p_araddr;
    logic [7:0]    p_awlen, p_arlen;
    logic          p_wlast;
    bit aw_stall, w_stall, ar_stall, b_pend, b_fire, r_pend, r_active, r_fire;
    int w_beat, w_len, r_beat, r_len, b_n;

    task automatic clear_stats();
        aw_addr_q.delete(); ar_addr_q.delete(); aw_len_q.delete(); ar_len_q.delete();
        wr_bytes = 0; wr_mism = 0; wlast_bad = 0; stab_bad = 0;
        fixed_bad = 0; r_beats = 0; w_total = 0;
    endtask

    task automatic slave_clear();
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        bvalid = 1'b0; bresp = 2'b00; bid = '0;
        rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rid = '0;
        wl = {slv_seed, 32'h0}; rl = {slv_seed, 32'h0};
        aw_stall = 0; w_stall = 0; ar_stall = 0; b_pend = 0; b_fire = 0;
        r_pend = 0; r_active = 0; r_fire = 0;
        w_beat = 0; w_len = 0; r_beat = 0; r_len = 0; b_n = 0;
    endtask

    // LFSR-responding AXI slave, evaluated on the falling edge
    initial begin
        slave_clear();
        clear_stats();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                slave_clear();
            end else begin
                if (b_fire) bvalid = 1'b0;
                if (r_fire) begin
                    r_beats++;
                    rl = {rl[DW-2:0], rl[DW-1] ^ rl[DW-2]};
                    if (r_beat == r_len) r_active = 0;
                    else r_beat++;
                end
                if (r_pend) begin
                    r_active = 1; r_pend = 0;
                end
                if (aw_stall && (!awvalid || awaddr !== p_awaddr || awlen !== p_awlen)) stab_bad++;
                if (w_stall && (!wvalid || wdata !== p_wdata || wlast !== p_wlast)) stab_bad++;
                if (ar_stall && (!arvalid || araddr !== p_araddr || arlen !== p_arlen)) stab_bad++;

                awready = bp_en ? 1'($urandom_range(1, 0)) : 1'b1;
                wready  = bp_en ? 1'($urandom_range(1, 0)) : 1'b1;
                arready = bp_en ? 1'($urandom_range(1, 0)) : 1'b1;

                if (awvalid && awready) begin
                    aw_addr_q.push_back(awaddr); aw_len_q.push_back(awlen);
                    w_len = int'(awlen); w_beat = 0;
                    if (awsize !== 3'd3 || awburst !== 2'b01 || awid !== '0) fixed_bad++;
                end
                aw_stall = awvalid && !awready;
                p_awaddr = awaddr; p_awlen = awlen;

                if (b_pend && !bvalid) begin
                    bvalid = 1'b1;
                    bresp  = (b_n == bresp_burst) ? 2'b10 : 2'b00;
                    b_pend = 0; b_n++;
                end
                if (wvalid && wready) begin
                    if (wdata !== wl) wr_mism++;
                    wl = {wl[DW-2:0], wl[DW-1] ^ wl[DW-2]};
                    wr_bytes += DW / 8; w_total++;
                    if (wlast !== (w_beat == w_len)) wlast_bad++;
                    if (wstrb !== 8'hFF) fixed_bad++;
                    if (w_beat == w_len) b_pend = 1;
                    w_beat++;
                end
                w_stall = wvalid && !wready;
                p_wdata = wdata; p_wlast = wlast;
                b_fire = bvalid && bready;

                if (arvalid && arready) begin
                    ar_addr_q.push_back(araddr); ar_len_q.push_back(arlen);
                    r_len = int'(arlen); r_beat = 0; r_pend = 1;
                    if (arsize !== 3'd3 || arburst !== 2'b01 || arid !== '0) fixed_bad++;
                end
                ar_stall = arvalid && !arready;
                p_araddr = araddr; p_arlen = arlen;

                if (r_active) begin
                    rvalid = bp_en ? 1'($urandom_range(1, 0)) : 1'b1;
                    rdata  = rl;
                    rlast  = (rlast_early >= 0) ? (r_beat == rlast_early) : (r_beat == r_len);
                end else begin
                    rvalid = 1'b0; rlast = 1'b0;
                end
                r_fire = rvalid && rready;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0;
        repeat (2) begin @(posedge clk); #2; end
        rst_n = 1'b1;
        clear_stats();
    endtask

    task automatic pulse_start(input logic [31:0] s, input logic [15:0] n);
        @(posedge clk); #2;
        seed = s; addr = '0; nbeats = n; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(output int dcnt);
        dcnt = 0;
        for (int c = 0; c < 4000 && dcnt == 0; c++) begin
            @(posedge clk); #2;
            if (done) dcnt++;
        end
        repeat (4) begin
            @(posedge clk); #2;
            if (done) dcnt++;
        end
    endtask

    int dc;

    initial begin
        rst_n = 1'b0; start = 1'b0; seed = '0; addr = '0; nbeats = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_mism", mism, 0);
        check("rst_handshakes", {awvalid, wvalid, bready, arvalid, rready}, 0);
        rst_n = 1'b1;
        clear_stats();

        // Matching seed, 40 beats
        pulse_start(32'h12345678, 16'd40);
        check("t1_aw_next_cycle", awvalid, 1);
        check("t1_busy", busy, 1);
        wait_done(dc);
        check("t1_done_once", dc, 1);
        check("t1_aw_cnt", aw_addr_q.size(), 3);
        check("t1_aw0", aw_addr_q[0], 'h000);
        check("t1_aw1", aw_addr_q[1], 'h080);
        check("t1_aw2", aw_addr_q[2], 'h100);
        check("t1_awlen", {aw_len_q[0], aw_len_q[1], aw_len_q[2]}, {8'd15, 8'd15, 8'd7});
        check("t1_ar_addr", {ar_addr_q[0], ar_addr_q[1], ar_addr_q[2]}, {30'h000, 30'h080, 30'h100});
        check("t1_arlen", {ar_len_q[0], ar_len_q[1], ar_len_q[2]}, {8'd15, 8'd15, 8'd7});
        check("t1_err", err, 0);
        check("t1_mism", mism, 0);
        check("t1_wr_bytes", wr_bytes, 320);
        check("t1_wr_data", wr_mism, 0);
        check("t1_wlast", wlast_bad, 0);
        check("t1_fixed", fixed_bad, 0);
        check("t1_r_beats", r_beats, 40);
        check("t1_busy_end", busy, 0);

        // Slave seeded differently
        slv_seed = 32'h12345679;
        do_reset();
        pulse_start(32'h12345678, 16'd40);
        wait_done(dc);
        check("t2_done_once", dc, 1);
        check("t2_err", err, 1);
        check("t2_mism", mism, 40);

        // Zero beats
        slv_seed = 32'h12345678;
        do_reset();
        pulse_start(32'h12345678, 16'd0);
        check("t3_busy_c1", {busy, done}, 2'b10);
        @(posedge clk); #2;
        check("t3_busy_c2", {busy, done}, 2'b01);
        @(posedge clk); #2;
        check("t3_busy_c3", {busy, done}, 2'b00);
        check("t3_no_aw_ar", aw_addr_q.size() + ar_addr_q.size(), 0);

        // Backpressure and SLVERR on second write burst
        bp_en = 1'b1; bresp_burst = 1;
        do_reset();
        pulse_start(32'h12345678, 16'd40);
        wait_done(dc);
        check("t4_done_once", dc, 1);
        check("t4_err", err, 1);
        check("t4_mism", mism, 0);
        check("t4_stable", stab_bad, 0);
        check("t4_aw_cnt", aw_addr_q.size(), 3);
        check("t4_wr_data", wr_mism, 0);
        bp_en = 1'b0; bresp_burst = -1;

        // Reset during write data, then clean restart
        do_reset();
        pulse_start(32'h12345678, 16'd40);
        for (int c = 0; c < 200 && w_total < 5; c++) begin
            @(posedge clk); #2;
        end
        check("t5_reached_beat5", w_total, 5);
        rst_n = 1'b0;
        @(posedge clk); #2;
        check("t5_valids_low", {awvalid, wvalid, arvalid}, 3'b000);
        check("t5_busy_low", busy, 0);
        rst_n = 1'b1;
        clear_stats();
        pulse_start(32'h12345678, 16'd40);
        wait_done(dc);
        check("t5_done_once", dc, 1);
        check("t5_err", err, 0);
        check("t5_mism", mism, 0);
        check("t5_wr_bytes", wr_bytes, 320);

        // Early RLAST on beat 3 of 8
        rlast_early = 2;
        do_reset();
        pulse_start(32'h12345678, 16'd8);
        wait_done(dc);
        check("t6_done_once", dc, 1);
        check("t6_err", err, 1);
        check("t6_mism", mism, 0);
        check("t6_r_beats", r_beats, 8);
        check("t6_arlen", {ar_addr_q.size(), ar_len_q[0]}, {32'd1, 8'd7});
        rlast_early = -1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
